ob_table_cnt_csa_acc: RTL and testbench
=======================================

Name: ob_table_cnt_csa_acc

Overview:
- Pipelined multi-lane running-sum accumulator for order-book table counting.
- Each accepted beat presents up to N W-bit words, each gated by a per-lane mask.
- The beat is reduced N->2 by a carry-save tree, then merged 4->2 into a carry-save accumulator held in registers.
- On request, a multi-cycle chunked carry-propagate adder resolves the accumulator into a binary sum.
- Sits between the table lookup datapath and the count/report logic.

Parameters:
- W, 32, width of each word, the accumulator and the result.
- N, 8, number of input lanes per beat; must be >= 1.
- OP, ob_pkg::CSA_3_2, compressor used in the reduction tree; CSA_3_2 or CSA_4_2.
- CPA_CHUNK, 8, bits resolved per resolve cycle. R = ceil(W/CPA_CHUNK).

Ports:
- clk  in  1  clock.
- arst_n  in  1  asynchronous, active-low reset.
- in_vld  in  1  input beat valid.
- in_rdy  out  1  block accepts a beat (accepted = in_vld & in_rdy).
- in_x  in  N*W  lane words, packed [N-1:0][W-1:0].
- in_msk  in  N  per-lane enable; a masked lane contributes 0.
- in_clr  in  1  with an accepted beat: discard the prior total, so the sum restarts at this beat.
- rd_req  in  1  request result (accepted = rd_req & in_rdy).
- rd_clr  in  1  with an accepted rd_req: zero the accumulator after the snapshot.
- out_vld  out  1  result valid, single-cycle pulse.
- out_sum  out  W  resolved sum mod 2^W; holds its value until the next result.
- out_ovf  out  1  overflow flag (see Optional Feature); 0 when the feature is disabled.

Behaviour:
- Reset (async assert, sync deassert at the design level):
  - state=IDLE, in_rdy=1, out_vld=0, out_sum=0, out_ovf=0.
  - acc_s=acc_c=0, stage-1 valid=0.
- Stage 1 (register):
  - Lanes are masked, then reduced by the tree sub-module.
  - The tree output pair is registered together with vld and clr.
- Stage 2 (register):
  - If s1_vld, acc <= csa4_2(s1_clr ? 0 : acc_s, s1_clr ? 0 : acc_c, s1_s, s1_c).
  - Otherwise acc holds.
- Latency: a beat accepted at cycle t is included in acc at the t+2 edge.
- All arithmetic is unsigned mod 2^W. The carry shifted out of bit W-1 is dropped.
- FSM states IDLE -> DRAIN -> RESOLVE -> DONE -> IDLE.
  - IDLE: in_rdy=1. An accepted rd_req moves to DRAIN.
  - DRAIN (1 cycle): in_rdy=0; the stage-1 beat, if any, is folded in.
  - RESOLVE (R cycles): in_rdy=0.
    - Cycle k adds chunk k of a snapshot of acc_s+acc_c, plus a registered chunk carry, into out_sum[k].
    - The snapshot is taken on entry to RESOLVE.
    - If rd_clr, acc is zeroed on entry to RESOLVE.
  - DONE (1 cycle): out_vld=1, in_rdy=0, then back to IDLE.
- rd_req accepted at cycle t -> out_vld at cycle t+R+2. in_rdy returns to 1 at t+R+3.
- Simultaneous in_vld and rd_req in IDLE: the beat is accepted and included in the result.
- Simultaneous in_clr and rd_req: the result equals that beat alone.
- in_clr on a beat with all lanes masked: the total becomes 0.
- rd_req while in_rdy=0 is ignored; the requester must hold it.
- in_vld while in_rdy=0 is not accepted; the source must hold it.
- Reset mid-RESOLVE: aborts the resolve and returns all state to reset values. No out_vld is produced.

Optional Feature:
- Macro OB_TABLE_CNT_CSA_ACC_OVF_EN.
- When defined:
  - A sticky ovf bit is set by any carry dropped at bit W in the tree or the 4->2 merge.
  - It is also set by the final chunk carry-out during RESOLVE.
  - Inputs are unsigned, so any dropped carry implies true sum >= 2^W.
  - ovf clears together with the accumulator (in_clr or rd_clr).
  - out_ovf presents the sticky value, snapshotted at RESOLVE entry and OR'd with the final carry-out, and is valid with out_vld.
- When undefined: no overflow logic; out_ovf is tied to 0.

Decomposition:
- ob_pkg holds:
  - csa_op_t (extended with CSA_4_2).
  - cnt_acc_state_t enum {IDLE, DRAIN, RESOLVE, DONE}.
  - A function returning R from W and CPA_CHUNK.
- Sub-module ob_table_cnt_csa_tree: combinational N->2 reduction parameterised by W, N and OP.
  - With the feature enabled it also outputs a dropped-carry flag.
  - The top level instantiates it once and owns all registers and the FSM.

Test Plan:
- W=8, N=4, CPA_CHUNK=4, all lanes enabled.
  - Beat {1,2,3,4}, then rd_req -> out_vld after R+2=4 cycles, out_sum=10, out_ovf=0.
- Three back-to-back beats {10,10,10,10}, then rd_req with rd_clr=1 -> out_sum=120. A following rd_req -> out_sum=0.
- in_msk=4'b0101 on {5,6,7,8}, then rd_req -> out_sum=12. Checks that masked lanes contribute 0.
- Accumulate 50; then beat {1,1,1,1} with in_clr=1 and rd_req asserted in the same cycle -> out_sum=4.
- OVF_EN defined: beats {255,255,0,0} -> out_sum=254 (510 mod 256), out_ovf=1. With OVF_EN undefined -> out_ovf=0.
- Deassert arst_n during RESOLVE -> no out_vld, out_sum=0, in_rdy=1 once reset is released. A new beat {1,1,1,1} -> out_sum=4.

Source files
------------

// File: rtl/ob_pkg.sv
// Shared types and helpers for the order-book table counting accumulator.
package ob_pkg;

  typedef enum logic {
    CSA_3_2,
    CSA_4_2
  } csa_op_t;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    RESOLVE,
    DONE
  } cnt_acc_state_t;

  // Number of chunked carry-propagate cycles needed to resolve a w-bit sum.
  function automatic int unsigned cpa_rounds(input int unsigned w, input int unsigned chunk);
    return (w + chunk - 1) / chunk;
  endfunction

endpackage

// File: rtl/ob_table_cnt_csa_tree.sv
// Combinational N->2 carry-save reduction of the masked lane words.
// Optional dropped-carry output under OB_TABLE_CNT_CSA_ACC_OVF_EN.
module ob_table_cnt_csa_tree
  import ob_pkg::*;
#(
  parameter int unsigned W  = 32,
  parameter int unsigned N  = 8,
  parameter csa_op_t     OP = CSA_3_2
) (
  input  logic [N-1:0][W-1:0] x,
  output logic [W-1:0]        s,
  output logic [W-1:0]        c
`ifdef OB_TABLE_CNT_CSA_ACC_OVF_EN
  ,
  output logic                drop
`endif
);

  function automatic logic [2*W-1:0] csa(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [W-1:0] d);
    return {a ^ b ^ d, ((a & b) | (a & d) | (b & d)) << 1};
  endfunction

`ifdef OB_TABLE_CNT_CSA_ACC_OVF_EN
  function automatic logic csa_drop(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic [W-1:0] d);
    return (a[W-1] & b[W-1]) | (a[W-1] & d[W-1]) | (b[W-1] & d[W-1]);
  endfunction
`endif

  logic [W-1:0] ps, pc, t_s, t_c;

  always_comb begin
    ps  = '0;
    pc  = '0;
    t_s = '0;
    t_c = '0;
`ifdef OB_TABLE_CNT_CSA_ACC_OVF_EN
    drop = 1'b0;
`endif
    if (OP == CSA_4_2) begin
      // each 4:2 step folds two lanes through two chained 3:2 compressors
      for (int unsigned i = 0; i + 1 < N; i += 2) begin
        {t_s, t_c} = csa(ps, pc, x[i]);
`ifdef OB_TABLE_CNT_CSA_ACC_OVF_EN
        drop = drop | csa_drop(ps, pc, x[i]) | csa_drop(t_s, t_c, x[i+1]);
`endif
        {ps, pc} = csa(t_s, t_c, x[i+1]);
      end
      if (N % 2 == 1) begin
`ifdef OB_TABLE_CNT_CSA_ACC_OVF_EN
        drop = drop | csa_drop(ps, pc, x[N-1]);
`endif
        {ps, pc} = csa(ps, pc, x[N-1]);
      end
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
`ifdef OB_TABLE_CNT_CSA_ACC_OVF_EN
        drop = drop | csa_drop(ps, pc, x[i]);
`endif
        {ps, pc} = csa(ps, pc, x[i]);
      end
    end
    s = ps;
    c = pc;
  end

endmodule

// File: rtl/ob_table_cnt_csa_acc.sv
// Pipelined multi-lane carry-save running-sum accumulator with chunked resolve.
// Sticky overflow tracking is enabled by defining OB_TABLE_CNT_CSA_ACC_OVF_EN.
module ob_table_cnt_csa_acc
  import ob_pkg::*;
#(
  parameter int unsigned W         = 32,
  parameter int unsigned N         = 8,
  parameter csa_op_t     OP        = CSA_3_2,
  parameter int unsigned CPA_CHUNK = 8
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic                in_vld,
  output logic                in_rdy,
  input  logic [N-1:0][W-1:0] in_x,
  input  logic [N-1:0]        in_msk,
  input  logic                in_clr,
  input  logic                rd_req,
  input  logic                rd_clr,
  output logic                out_vld,
  output logic [W-1:0]        out_sum,
  output logic                out_ovf
);

  localparam int unsigned R  = cpa_rounds(W, CPA_CHUNK);
  localparam int unsigned PW = R * CPA_CHUNK;
  localparam int unsigned KW = (R > 1) ? $clog2(R) : 1;

  function automatic logic [2*W-1:0] csa(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [W-1:0] d);
    return {a ^ b ^ d, ((a & b) | (a & d) | (b & d)) << 1};
  endfunction

  cnt_acc_state_t state, state_nxt;
  logic [N-1:0][W-1:0] x_m;
  logic [W-1:0] t_s, t_c, s1_s, s1_c, acc_s, acc_c;
  logic [W-1:0] base_s, base_c, m0_s, m0_c, m_s, m_c, acc_s_nxt, acc_c_nxt;
  logic [PW-1:0] snap_s, snap_c;
  logic [CPA_CHUNK:0] ext;
  logic [KW-1:0] k;
  logic s1_vld, s1_clr, rd_clr_q, cy_q, in_acc, rd_acc;

`ifdef OB_TABLE_CNT_CSA_ACC_OVF_EN
  // bit position of weight 2^W inside the last chunk's {carry, sum}
  localparam int unsigned LB = W - (R - 1) * CPA_CHUNK;

  function automatic logic csa_drop(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic [W-1:0] d);
    return (a[W-1] & b[W-1]) | (a[W-1] & d[W-1]) | (b[W-1] & d[W-1]);
  endfunction

  logic t_drop, s1_drop, acc_ovf, acc_ovf_nxt, snap_ovf;
`endif

  assign in_acc = in_vld & in_rdy;
  assign rd_acc = rd_req & in_rdy;

  always_comb begin
    for (int unsigned i = 0; i < N; i++) x_m[i] = in_msk[i] ? in_x[i] : '0;
  end

  ob_table_cnt_csa_tree #(
    .W (W),
    .N (N),
    .OP(OP)
  ) u_tree (
    .x   (x_m),
    .s   (t_s),
    .c   (t_c)
`ifdef OB_TABLE_CNT_CSA_ACC_OVF_EN
    ,
    .drop(t_drop)
`endif
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      s1_vld  <= 1'b0;
      s1_clr  <= 1'b0;
      s1_s    <= '0;
      s1_c    <= '0;
`ifdef OB_TABLE_CNT_CSA_ACC_OVF_EN
      s1_drop <= 1'b0;
`endif
    end else begin
      s1_vld <= in_acc;
      s1_clr <= in_acc & in_clr;
      if (in_acc) begin
        s1_s    <= t_s;
        s1_c    <= t_c;
`ifdef OB_TABLE_CNT_CSA_ACC_OVF_EN
        s1_drop <= t_drop;
`endif
      end
    end
  end

  always_comb begin
    base_s = s1_clr ? '0 : acc_s;
    base_c = s1_clr ? '0 : acc_c;
    {m0_s, m0_c} = csa(base_s, base_c, s1_s);
    {m_s, m_c}   = csa(m0_s, m0_c, s1_c);
    acc_s_nxt = s1_vld ? m_s : acc_s;
    acc_c_nxt = s1_vld ? m_c : acc_c;
`ifdef OB_TABLE_CNT_CSA_ACC_OVF_EN
    acc_ovf_nxt = s1_vld ? ((~s1_clr & acc_ovf) | s1_drop | csa_drop(base_s, base_c, s1_s) |
                            csa_drop(m0_s, m0_c, s1_c))
                         : acc_ovf;
`endif
  end

  assign ext = {1'b0, snap_s[CPA_CHUNK-1:0]} + {1'b0, snap_c[CPA_CHUNK-1:0]} +
               {{CPA_CHUNK{1'b0}}, cy_q};

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_rdy    = 1'b0;
    out_vld   = 1'b0;
    unique case (state)
      IDLE: begin
        in_rdy = 1'b1;
        if (rd_req) state_nxt = DRAIN;
      end
      DRAIN:   state_nxt = RESOLVE;
      RESOLVE: if (k == KW'(R - 1)) state_nxt = DONE;
      DONE: begin
        out_vld   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      acc_s    <= '0;
      acc_c    <= '0;
      snap_s   <= '0;
      snap_c   <= '0;
      k        <= '0;
      cy_q     <= 1'b0;
      rd_clr_q <= 1'b0;
      out_sum  <= '0;
`ifdef OB_TABLE_CNT_CSA_ACC_OVF_EN
      acc_ovf  <= 1'b0;
      snap_ovf <= 1'b0;
      out_ovf  <= 1'b0;
`endif
    end else begin
      if (rd_acc) rd_clr_q <= rd_clr;
      if (state == DRAIN) begin
        // snapshot the next-state value so the beat folded during DRAIN is included
        snap_s <= PW'(acc_s_nxt);
        snap_c <= PW'(acc_c_nxt);
        k      <= '0;
        cy_q   <= 1'b0;
        acc_s  <= rd_clr_q ? '0 : acc_s_nxt;
        acc_c  <= rd_clr_q ? '0 : acc_c_nxt;
`ifdef OB_TABLE_CNT_CSA_ACC_OVF_EN
        snap_ovf <= acc_ovf_nxt;
        acc_ovf  <= rd_clr_q ? 1'b0 : acc_ovf_nxt;
`endif
      end else begin
        acc_s <= acc_s_nxt;
        acc_c <= acc_c_nxt;
`ifdef OB_TABLE_CNT_CSA_ACC_OVF_EN
        acc_ovf <= acc_ovf_nxt;
`endif
        if (state == RESOLVE) begin
          snap_s <= snap_s >> CPA_CHUNK;
          snap_c <= snap_c >> CPA_CHUNK;
          cy_q   <= ext[CPA_CHUNK];
          k      <= k + 1'b1;
          for (int unsigned b = 0; b < W; b++) begin
            if (KW'(b / CPA_CHUNK) == k) out_sum[b] <= ext[b % CPA_CHUNK];
          end
`ifdef OB_TABLE_CNT_CSA_ACC_OVF_EN
          if (k == KW'(R - 1)) out_ovf <= snap_ovf | ext[LB];
`endif
        end
      end
    end
  end

`ifndef OB_TABLE_CNT_CSA_ACC_OVF_EN
  assign out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_ob_table_cnt_csa_acc.sv
// Directed bench for ob_table_cnt_csa_acc: both compressor variants against a running-total model.
module tb_ob_table_cnt_csa_acc;
  import ob_pkg::*;

  localparam int unsigned W = 8;
  localparam int unsigned N = 4;
  localparam int unsigned C = 4;
  localparam int R = (W + C - 1) / C;

  logic clk = 1'b0, arst_n = 1'b0;
  logic in_vld = 1'b0, in_clr = 1'b0, rd_req = 1'b0, rd_clr = 1'b0;
  logic [N-1:0][W-1:0] in_x = '0;
  logic [N-1:0] in_msk = '0;
  logic rdy3, vld3, ovf3, rdy4, vld4, ovf4;
  logic [W-1:0] sum3, sum4;

  ob_table_cnt_csa_acc #(.W(W), .N(N), .OP(CSA_3_2), .CPA_CHUNK(C)) dut3 (
    .clk(clk), .arst_n(arst_n), .in_vld(in_vld), .in_rdy(rdy3), .in_x(in_x), .in_msk(in_msk),
    .in_clr(in_clr), .rd_req(rd_req), .rd_clr(rd_clr), .out_vld(vld3), .out_sum(sum3),
    .out_ovf(ovf3));

  ob_table_cnt_csa_acc #(.W(W), .N(N), .OP(CSA_4_2), .CPA_CHUNK(C)) dut4 (
    .clk(clk), .arst_n(arst_n), .in_vld(in_vld), .in_rdy(rdy4), .in_x(in_x), .in_msk(in_msk),
    .in_clr(in_clr), .rd_req(rd_req), .rd_clr(rd_clr), .out_vld(vld4), .out_sum(sum4),
    .out_ovf(ovf4));

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // transaction-level model: unbounded running total and the pending-result window
  longint m_total = 0;
  int busy_lo = 1, busy_hi = 0, vld_cyc = -100;
  logic [W-1:0] e_sum = '0, last3 = '0, last4 = '0;
  logic e_ovf = 1'b0, lovf3 = 1'b0, lovf4 = 1'b0;
  int got3 = 0, got4 = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!arst_n) begin
      chk("rst_rdy3", W'(rdy3), 1); chk("rst_vld3", W'(vld3), 0);
      chk("rst_sum3", sum3, 0);     chk("rst_ovf3", W'(ovf3), 0);
      chk("rst_rdy4", W'(rdy4), 1); chk("rst_vld4", W'(vld4), 0);
      chk("rst_sum4", sum4, 0);     chk("rst_ovf4", W'(ovf4), 0);
    end else begin
      logic e_rdy, e_v;
      e_rdy = !(cyc >= busy_lo && cyc <= busy_hi);
      e_v   = (cyc == vld_cyc);
      chk("rdy3", W'(rdy3), W'(e_rdy)); chk("vld3", W'(vld3), W'(e_v));
      chk("rdy4", W'(rdy4), W'(e_rdy)); chk("vld4", W'(vld4), W'(e_v));
      if (e_v) begin
        chk("sum3", sum3, e_sum); chk("ovf3", W'(ovf3), W'(e_ovf));
        chk("sum4", sum4, e_sum); chk("ovf4", W'(ovf4), W'(e_ovf));
      end
      if (vld3) begin last3 = sum3; lovf3 = ovf3; got3++; end
      if (vld4) begin last4 = sum4; lovf4 = ovf4; got4++; end
    end
  end

  function automatic logic [N-1:0][W-1:0] lanes(input int a, input int b, input int c, input int d);
    return {W'(d), W'(c), W'(b), W'(a)};
  endfunction

  // one cycle of stimulus; the model decides acceptance from its own ready window
  task automatic op(input logic v, input logic [N-1:0][W-1:0] x, input logic [N-1:0] m,
                    input logic c, input logic r, input logic rc);
    logic rdy;
    rdy = !(cyc >= busy_lo && cyc <= busy_hi);
    in_vld = v; in_x = x; in_msk = m; in_clr = c; rd_req = r; rd_clr = rc;
    if (rdy && v) begin
      if (c) m_total = 0;
      for (int i = 0; i < N; i++) if (m[i]) m_total += longint'(x[i]);
    end
    if (rdy && r) begin
      e_sum = m_total[W-1:0];
`ifdef OB_TABLE_CNT_CSA_ACC_OVF_EN
      e_ovf = (m_total >= (longint'(1) << W));
`else
      e_ovf = 1'b0;
`endif
      vld_cyc = cyc + R + 2;
      busy_lo = cyc + 1;
      busy_hi = cyc + R + 2;
      if (rc) m_total = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    op(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic beat(input logic [N-1:0][W-1:0] x, input logic [N-1:0] m, input logic c);
    op(1'b1, x, m, c, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic rc);
    op(1'b0, '0, '0, 1'b0, 1'b1, rc);
  endtask

  // wait out the result window, then pin the captured result to a literal
  task automatic read_done(input string name, input int g3, input int g4,
                           input logic [W-1:0] lsum, input logic lovf);
    int guard;
    logic xo;
    guard = 0;
    idle();
    while (cyc <= busy_hi && guard < 40) begin
      idle();
      guard++;
    end
`ifdef OB_TABLE_CNT_CSA_ACC_OVF_EN
    xo = lovf;
`else
    xo = 1'b0;
`endif
    chk({name, "_cnt3"}, W'(got3 - g3), 1);
    chk({name, "_cnt4"}, W'(got4 - g4), 1);
    chk({name, "_lit3"}, last3, lsum);
    chk({name, "_lit4"}, last4, lsum);
    chk({name, "_ovf3"}, W'(lovf3), W'(xo));
    chk({name, "_ovf4"}, W'(lovf4), W'(xo));
  endtask

  initial begin
    int g3, g4, guard;
    repeat (3) @(posedge clk);
    #1 arst_n = 1'b1;
    idle();

    g3 = got3; g4 = got4;
    beat(lanes(1, 2, 3, 4), 4'hf, 1'b0);
    rd(1'b1);
    read_done("basic", g3, g4, 10, 1'b0);

    g3 = got3; g4 = got4;
    repeat (3) beat(lanes(10, 10, 10, 10), 4'hf, 1'b0);
    rd(1'b1);
    read_done("b2b", g3, g4, 120, 1'b0);
    g3 = got3; g4 = got4;
    rd(1'b0);
    read_done("rdclr", g3, g4, 0, 1'b0);

    g3 = got3; g4 = got4;
    beat(lanes(5, 6, 7, 8), 4'b0101, 1'b0);
    rd(1'b1);
    read_done("mask", g3, g4, 12, 1'b0);

    g3 = got3; g4 = got4;
    beat(lanes(10, 10, 10, 10), 4'hf, 1'b0);
    beat(lanes(10, 0, 0, 0), 4'b0001, 1'b0);
    op(1'b1, lanes(1, 1, 1, 1), 4'hf, 1'b1, 1'b1, 1'b0);
    read_done("clr_rd", g3, g4, 4, 1'b0);

    g3 = got3; g4 = got4;
    beat(lanes(255, 255, 0, 0), 4'hf, 1'b1);
    rd(1'b1);
    read_done("ovf", g3, g4, 254, 1'b1);

    // requests and beats while busy must be ignored
    g3 = got3; g4 = got4;
    beat(lanes(3, 0, 0, 0), 4'b0001, 1'b0);
    rd(1'b0);
    guard = 0;
    while (cyc <= busy_hi && guard < 40) begin
      op(1'b1, lanes(7, 7, 7, 7), 4'hf, 1'b0, 1'b1, 1'b0);
      guard++;
    end
    read_done("busy1", g3, g4, 3, 1'b0);
    g3 = got3; g4 = got4;
    rd(1'b1);
    read_done("busy2", g3, g4, 3, 1'b0);

    g3 = got3; g4 = got4;
    beat(lanes(9, 9, 9, 9), 4'hf, 1'b0);
    beat(lanes(9, 9, 9, 9), 4'b0000, 1'b1);
    rd(1'b0);
    read_done("mclr", g3, g4, 0, 1'b0);
    g3 = got3; g4 = got4;
    beat(lanes(200, 200, 200, 200), 4'hf, 1'b0);
    rd(1'b1);
    read_done("wrap", g3, g4, 32, 1'b1);

    // reset during the first RESOLVE cycle aborts the result
    g3 = got3; g4 = got4;
    beat(lanes(2, 2, 2, 2), 4'hf, 1'b0);
    rd(1'b0);
    idle();
    arst_n = 1'b0;
    m_total = 0; busy_lo = 1; busy_hi = 0; vld_cyc = -100;
    repeat (2) idle();
    arst_n = 1'b1;
    repeat (6) idle();
    chk("abort_cnt3", W'(got3 - g3), 0);
    chk("abort_cnt4", W'(got4 - g4), 0);
    g3 = got3; g4 = got4;
    beat(lanes(1, 1, 1, 1), 4'hf, 1'b0);
    rd(1'b1);
    read_done("post_rst", g3, g4, 4, 1'b0);

    repeat (2) idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
